freelist_alloc: RTL

- Physical-register free-list allocator for the rename stage.
- Holds a SIZE-bit free bitmap and hands out the lowest-index free entry every cycle through a priority encoder.
- Takes back at most one entry per cycle from commit.
- Tracks the free count for rename stall control.

---
 rtl/freelist_alloc.sv | 103 ++++++++++
 1 files changed

// File: rtl/freelist_alloc.sv
// Physical-register free list: SIZE-bit free bitmap, lowest-index allocate,
// one release per cycle, free count for rename stall control.
// Ports: i_clk, i_rst_n (async, active low), i_alloc_req -> o_alloc_vld/o_alloc_idx,
// i_rel_en/i_rel_idx release, i_flush reinit, o_free_cnt, o_empty, o_err.
// Option: define FREELIST_DBLFREE_CHK_EN to flag double/reserved releases on o_err.
module freelist_alloc #(
  parameter int SIZE     = 32,
  parameter int WIDTH    = 5,
  parameter int RESERVED = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_alloc_req,
  output logic             o_alloc_vld,
  output logic [WIDTH-1:0] o_alloc_idx,
  input  logic             i_rel_en,
  input  logic [WIDTH-1:0] i_rel_idx,
  input  logic             i_flush,
  output logic [WIDTH:0]   o_free_cnt,
  output logic             o_empty,
  output logic             o_err
);

  localparam logic [SIZE-1:0] LP_INIT = {SIZE{1'b1}} << RESERVED;
  localparam logic [WIDTH:0]  LP_CNT  = (WIDTH+1)'(SIZE - RESERVED);
  localparam logic [WIDTH:0]  LP_SIZE = (WIDTH+1)'(SIZE);
  localparam logic [WIDTH:0]  LP_RES  = (WIDTH+1)'(RESERVED);

  logic [SIZE-1:0]  r_map;
  logic [WIDTH:0]   r_cnt;

  logic             w_vld;
  logic [WIDTH-1:0] w_idx;
  logic             w_alloc_ok;
  logic             w_rel_low;
  logic             w_rel_inrange;
  logic             w_rel_bit;
  logic             w_rel_ok;
  logic [SIZE-1:0]  w_alloc_mask;
  logic [SIZE-1:0]  w_rel_mask;

  // Lowest set bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (r_map[i]) w_idx = WIDTH'(i);
    end
  end

  assign w_vld      = |r_map;
  assign w_alloc_ok = i_alloc_req && w_vld;

  assign w_rel_low     = {1'b0, i_rel_idx} < LP_RES;
  assign w_rel_inrange = !w_rel_low && ({1'b0, i_rel_idx} < LP_SIZE);

  always_comb begin
    w_rel_bit = 1'b0;
    if (w_rel_inrange) w_rel_bit = r_map[i_rel_idx];
  end

  assign w_rel_ok = i_rel_en && w_rel_inrange && !w_rel_bit;

  assign w_alloc_mask = w_alloc_ok ? (SIZE'(1) << w_idx) : '0;
  assign w_rel_mask   = w_rel_ok ? (SIZE'(1) << i_rel_idx) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_map <= LP_INIT;
      r_cnt <= LP_CNT;
    end else if (i_flush) begin
      r_map <= LP_INIT;
      r_cnt <= LP_CNT;
    end else begin
      // Allocated bit is free, released bit is not: masks never overlap.
      r_map <= (r_map & ~w_alloc_mask) | w_rel_mask;
      r_cnt <= r_cnt + (WIDTH+1)'(w_rel_ok) - (WIDTH+1)'(w_alloc_ok);
    end
  end

`ifdef FREELIST_DBLFREE_CHK_EN
  logic r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (i_flush) begin
      r_err <= 1'b0;
    end else begin
      r_err <= i_rel_en && (w_rel_low || w_rel_bit);
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_alloc_vld = w_vld;
  assign o_alloc_idx = w_idx;
  assign o_free_cnt  = r_cnt;
  assign o_empty     = (r_cnt == '0);

endmodule
